config_sequencer: RTL and testbench

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/config_seq_pkg.sv | 19 +
 rtl/config_sequencer_if.sv | 14 +
 rtl/config_sequencer_sclk_tick.sv | 25 ++
 rtl/config_sequencer.sv | 154 +++++++++++++++
 tb/tb_config_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/config_seq_pkg.sv
// Shared types and constants for the configuration sequencer.
package config_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCLK_HI,
    ST_SCLK_LO,
    ST_TAIL,
    ST_RENDER,
    ST_DONE
  } state_t;

  localparam int CFG_WIDTH_DEFAULT = 33;

  // Power-on configuration word: bits 26..29 set.
  localparam logic [CFG_WIDTH_DEFAULT-1:0] CFG_DEFAULT = 33'h0_3C00_0000;

endpackage

// File: rtl/config_sequencer_if.sv
// Request side of the sequencer: parallel word offer with valid/ready handshake.
interface config_sequencer_if
  import config_seq_pkg::*;
#(
  parameter int CFG_WIDTH = CFG_WIDTH_DEFAULT
);
  logic [CFG_WIDTH-1:0] cfg_data;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 auto_render;

  modport master (output cfg_data, output cfg_valid, output auto_render, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input auto_render, output cfg_ready);
endinterface

// File: rtl/config_sequencer_sclk_tick.sv
// Phase timer: reloads on every state entry and flags the last cycle of a phase.
module sclk_tick #(
  parameter int SCLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);
  localparam logic [7:0] LOAD = 8'(SCLK_DIV - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_restart) begin
      r_count <= LOAD;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_tick = (r_count == 8'd0);
endmodule

// File: rtl/config_sequencer.sv
// Serialises a parallel configuration word LSB first onto an enable/sclk/data
// interface, optionally followed by a render trigger pulse.
module config_sequencer
  import config_seq_pkg::*;
#(
  parameter int CFG_WIDTH     = CFG_WIDTH_DEFAULT,
  parameter int SCLK_DIV      = 1,
  parameter int RENDER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  config_sequencer_if.slave  cfg_if,
  output logic               ser_enable,
  output logic               ser_sclk,
  output logic               ser_data,
  output logic               render_req,
  output logic               busy,
  output logic               done
);
  localparam int               CNT_W       = $clog2(CFG_WIDTH + 1);
  localparam logic [CNT_W-1:0] BITS_LAST   = CNT_W'(CFG_WIDTH);
  localparam logic [7:0]       RENDER_LOAD = 8'(RENDER_CYCLES - 1);

  state_t               r_state;
  logic [CFG_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [7:0]           r_render_cnt;
  logic                 r_auto_render;
  logic                 r_cfg_ready;
  logic                 r_ser_enable;
  logic                 r_ser_sclk;
  logic                 r_ser_data;
  logic                 r_render_req;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_tick;
  logic                 w_restart;
  logic                 w_accept;
  logic [CFG_WIDTH-1:0] w_shift_next;

  // Holding the timer in reload while idle makes SETUP start with a full phase.
  assign w_restart    = (r_state == ST_IDLE) || w_tick;
  assign w_accept     = cfg_if.cfg_valid && r_cfg_ready;
  assign w_shift_next = r_shift >> 1;

  sclk_tick #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_tick (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_render_cnt  <= 8'd0;
      r_auto_render <= 1'b0;
      r_cfg_ready   <= 1'b0;
      r_ser_enable  <= 1'b0;
      r_ser_sclk    <= 1'b0;
      r_ser_data    <= 1'b0;
      r_render_req  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cfg_ready <= 1'b1;
          if (w_accept) begin
            r_state       <= ST_SETUP;
            r_cfg_ready   <= 1'b0;
            r_busy        <= 1'b1;
            r_shift       <= cfg_if.cfg_data;
            r_auto_render <= cfg_if.auto_render;
            r_bit_cnt     <= '0;
            r_ser_enable  <= 1'b1;
            r_ser_sclk    <= 1'b0;
            r_ser_data    <= cfg_if.cfg_data[0];
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_state    <= ST_SCLK_HI;
            r_ser_sclk <= 1'b1;
          end
        end
        ST_SCLK_HI: begin
          // Data advances on the falling sclk edge so it is stable at the next rise.
          if (w_tick) begin
            r_state    <= ST_SCLK_LO;
            r_ser_sclk <= 1'b0;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_ser_data <= w_shift_next[0];
          end
        end
        ST_SCLK_LO: begin
          if (w_tick) begin
            if (r_bit_cnt == BITS_LAST) begin
              r_state <= ST_TAIL;
            end else begin
              r_state    <= ST_SCLK_HI;
              r_ser_sclk <= 1'b1;
            end
          end
        end
        ST_TAIL: begin
          if (w_tick) begin
            r_ser_enable <= 1'b0;
            if (r_auto_render) begin
              r_state      <= ST_RENDER;
              r_render_req <= 1'b1;
              r_render_cnt <= RENDER_LOAD;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RENDER: begin
          if (r_render_cnt == 8'd0) begin
            r_state      <= ST_DONE;
            r_render_req <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_render_cnt <= r_render_cnt - 8'd1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_if.cfg_ready = r_cfg_ready;
  assign ser_enable       = r_ser_enable;
  assign ser_sclk         = r_ser_sclk;
  assign ser_data         = r_ser_data;
  assign render_req       = r_render_req;
  assign busy             = r_busy;
  assign done             = r_done;
endmodule

// File: tb/tb_config_sequencer.sv
// Scoreboard bench: two sequencers (SCLK_DIV 1 and 3) driven by directed loads.
module tb_config_sequencer;
  import config_seq_pkg::*;

  typedef struct {
    logic [32:0] word;
    int          lat;
    int          rnd;
    int          gap;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [32:0] s_data [2];
  logic [1:0]  s_valid;
  logic [1:0]  s_ar;
  wire  [1:0]  m_ready, m_en, m_sclk, m_data, m_render, m_busy, m_done;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  exp_t        exp_q [2][$];
  int          nbits [2];
  int          hi_len [2];
  int          lo_len [2];
  int          rnd_cnt [2];
  int          err [2];
  int          acc_edge [2];
  int          prev_acc [2];
  logic [32:0] acc_word [2];
  logic        prev_sclk [2];
  logic        prev_data [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    config_sequencer_if #(.CFG_WIDTH(33)) u_if ();
    assign u_if.cfg_data    = s_data[gi];
    assign u_if.cfg_valid   = s_valid[gi];
    assign u_if.auto_render = s_ar[gi];
    assign m_ready[gi]      = u_if.cfg_ready;

    config_sequencer #(
      .CFG_WIDTH     (33),
      .SCLK_DIV      ((gi == 0) ? 1 : 3),
      .RENDER_CYCLES (4)
    ) u_dut (
      .clk        (clk),
      .reset      (rst[gi]),
      .cfg_if     (u_if.slave),
      .ser_enable (m_en[gi]),
      .ser_sclk   (m_sclk[gi]),
      .ser_data   (m_data[gi]),
      .render_req (m_render[gi]),
      .busy       (m_busy[gi]),
      .done       (m_done[gi])
    );
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Done edge relative to the accept edge: 2*div*(33+1)+1, plus 4 with render.
  function automatic int lat(input int d, input bit ar);
    return 2 * d * 34 + 1 + (ar ? 4 : 0);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_acc(input int i);
    nbits[i]    = 0;
    hi_len[i]   = 0;
    rnd_cnt[i]  = 0;
    err[i]      = 0;
    acc_word[i] = '0;
  endtask

  task automatic mon_step(input int i);
    exp_t e;
    if (rst[i]) begin
      clear_acc(i);
      lo_len[i]    = 0;
      prev_sclk[i] = 1'b0;
      prev_data[i] = 1'b0;
      return;
    end
    if (s_valid[i] && m_ready[i]) begin
      prev_acc[i] = acc_edge[i];
      acc_edge[i] = cyc + 1;
    end
    if (m_sclk[i] && !prev_sclk[i]) begin
      if (nbits[i] > 0 && lo_len[i] != div_of(i)) err[i]++;
      if (nbits[i] < 33) acc_word[i][nbits[i]] = m_data[i];
      nbits[i]++;
      hi_len[i] = 0;
    end
    if (!m_sclk[i] && prev_sclk[i]) begin
      if (hi_len[i] != div_of(i)) err[i]++;
      lo_len[i] = 0;
    end
    if (m_sclk[i]) begin
      hi_len[i]++;
      if (prev_sclk[i] && (m_data[i] != prev_data[i])) err[i]++;
    end else begin
      lo_len[i]++;
    end
    if (m_sclk[i] && !m_en[i]) err[i]++;
    if (m_render[i]) begin
      rnd_cnt[i]++;
      if (m_en[i]) err[i]++;
    end
    if (m_ready[i] && m_busy[i]) err[i]++;
    if (m_done[i]) begin
      if (exp_q[i].size() == 0) begin
        check($sformatf("dut%0d_unexpected_done", i), 1, 0);
      end else begin
        e = exp_q[i].pop_front();
        $display("load dut%0d word=%h bits=%0d latency=%0d render=%0d", i, acc_word[i],
                 nbits[i], cyc + 1 - acc_edge[i], rnd_cnt[i]);
        check($sformatf("dut%0d_word", i), acc_word[i], e.word);
        check($sformatf("dut%0d_bits", i), nbits[i], 33);
        check($sformatf("dut%0d_latency", i), cyc + 1 - acc_edge[i], e.lat);
        check($sformatf("dut%0d_render_cycles", i), rnd_cnt[i], e.rnd);
        check($sformatf("dut%0d_phase_errors", i), err[i], 0);
        if (e.gap != 0) check($sformatf("dut%0d_accept_gap", i), acc_edge[i] - prev_acc[i], e.gap);
      end
      clear_acc(i);
    end
    prev_sclk[i] = m_sclk[i];
    prev_data[i] = m_data[i];
  endtask

  // Keeps cfg_valid high; the next word is presented as soon as cfg_ready is seen.
  task automatic stream(input int idx, input int n, input logic [32:0] w0, input logic [32:0] w1,
                        input logic [32:0] w2, input bit [2:0] ar, input bit noise);
    logic [32:0] w [3];
    exp_t e;
    int sent;
    int guard;
    int prev_lat;
    w[0] = w0; w[1] = w1; w[2] = w2;
    sent = 0; guard = 0; prev_lat = 0;
    while (1) begin
      if (m_ready[idx]) begin
        if (sent == n) begin
          s_valid[idx] = 1'b0;
          break;
        end
        s_valid[idx] = 1'b1;
        s_data[idx]  = w[sent];
        s_ar[idx]    = ar[sent];
        e.word = w[sent];
        e.lat  = lat(div_of(idx), ar[sent]);
        e.rnd  = ar[sent] ? 4 : 0;
        e.gap  = (sent == 0) ? 0 : prev_lat + 1;
        exp_q[idx].push_back(e);
        prev_lat = e.lat;
        sent++;
      end else if (noise) begin
        s_data[idx] = {1'($urandom), 32'($urandom)};
        s_ar[idx]   = 1'($urandom);
      end
      guard++;
      if (guard > 3000) begin
        check("stream_timeout", guard, 0);
        s_valid[idx] = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int edges;
    int guard;
    logic prev;
    rst     = 2'b11;
    s_valid = 2'b00;
    s_ar    = 2'b00;
    s_data[0] = '0;
    s_data[1] = '0;
    for (int i = 0; i < 2; i++) begin
      prev_sclk[i] = 1'b0; prev_data[i] = 1'b0; lo_len[i] = 0;
      acc_edge[i] = 0; prev_acc[i] = 0;
      clear_acc(i);
    end
    fork
      forever @(posedge clk) cyc++;
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) mon_step(i);
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d_reset_outputs", i),
            {m_ready[i], m_busy[i], m_done[i], m_en[i], m_sclk[i], m_data[i], m_render[i]}, 0);
    rst = 2'b00;
    #1;
    check("reset_release_ready_low", m_ready, 2'b00);
    @(posedge clk); #1;
    check("first_edge_ready_high", m_ready, 2'b11);

    stream(0, 1, CFG_DEFAULT, '0, '0, 3'b000, 1'b0);
    stream(0, 1, CFG_DEFAULT, '0, '0, 3'b001, 1'b0);
    stream(1, 1, 33'h1_5555_5555, '0, '0, 3'b000, 1'b0);
    stream(0, 2, 33'h0_A5A5_0F0F, 33'h1_0000_0001, '0, 3'b000, 1'b1);

    // Abort a load after 10 rising sclk edges.
    s_data[0]  = 33'h1_2345_6789;
    s_ar[0]    = 1'b1;
    s_valid[0] = 1'b1;
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    edges = 0; guard = 0; prev = 1'b0;
    while (edges < 10 && guard < 500) begin
      @(posedge clk); #1;
      if (m_sclk[0] && !prev) edges++;
      prev = m_sclk[0];
      guard++;
    end
    check("abort_sclk_edges", edges, 10);
    check("abort_busy_before_reset", m_busy[0], 1);
    #1;
    rst[0] = 1'b1;
    #1;
    check("abort_outputs_cleared",
          {m_ready[0], m_busy[0], m_done[0], m_en[0], m_sclk[0], m_data[0], m_render[0]}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    #1;
    check("abort_release_ready_low", m_ready[0], 0);
    @(posedge clk); #1;
    check("abort_first_edge_ready", m_ready[0], 1);
    stream(0, 1, 33'h1_FFFF_FFFF, '0, '0, 3'b000, 1'b0);

    stream(0, 3, 33'h1_8000_0001, 33'h0_DEAD_BEEF, 33'h1_2468_ACE0, 3'b010, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("dut0_pending_loads", exp_q[0].size(), 0);
    check("dut1_pending_loads", exp_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
